// File: rtl/matmul_gpio_driver.sv
// Host-side initiator for the matrix_multiply GPIO load/execute/read protocol.
// Optional golden-result checking: define MATMUL_DRV_CHECK_EN.
module matmul_gpio_driver #(
    parameter int HOLD_CYCLES = 2,
    parameter int EXEC_WAIT   = 4,
    parameter int SETTLE      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] out_data,
    output logic [1:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic [2:0]  mm_sel_in,
    output logic [7:0]  mm_input_val,
    output logic        mm_execute,
    output logic [1:0]  mm_sel_out,
    input  logic [16:0] mm_result
`ifdef MATMUL_DRV_CHECK_EN
   ,output logic        check_err
`endif
);

    typedef enum logic [2:0] {
        S_LOAD, S_HOLD, S_EXEC, S_WAIT, S_SETTLE, S_OUT
    } state_t;

    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST   = 8'(EXEC_WAIT - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  k_q, k_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [16:0] out_data_q, out_data_d;
    logic [1:0]  out_idx_q, out_idx_d;
    logic        out_last_q, out_last_d;
    logic        busy_q, busy_d;
    logic [2:0]  sel_in_q, sel_in_d;
    logic [7:0]  input_val_q, input_val_d;
    logic        execute_q, execute_d;
    logic [1:0]  sel_out_q, sel_out_d;

`ifdef MATMUL_DRV_CHECK_EN
    logic [7:0]  ops_q [8];
    logic [7:0]  ops_d [8];
    logic        check_err_q, check_err_d;
    logic [16:0] gold_k;

    // Golden C[k] = row(k/2) of A dotted with column(k%2) of B
    always_comb begin
        gold_k = '0;
        unique case (k_q)
            2'd0: gold_k = 17'(ops_q[0]) * 17'(ops_q[4])
                         + 17'(ops_q[1]) * 17'(ops_q[6]);
            2'd1: gold_k = 17'(ops_q[0]) * 17'(ops_q[5])
                         + 17'(ops_q[1]) * 17'(ops_q[7]);
            2'd2: gold_k = 17'(ops_q[2]) * 17'(ops_q[4])
                         + 17'(ops_q[3]) * 17'(ops_q[6]);
            2'd3: gold_k = 17'(ops_q[2]) * 17'(ops_q[5])
                         + 17'(ops_q[3]) * 17'(ops_q[7]);
            default: gold_k = '0;
        endcase
    end

    assign check_err = check_err_q;
`endif

    // Next-state and registered-output computation for the protocol sequencer
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        sel_in_d    = sel_in_q;
        input_val_d = input_val_q;
        execute_d   = 1'b0;
        sel_out_d   = sel_out_q;
`ifdef MATMUL_DRV_CHECK_EN
        ops_d       = ops_q;
        check_err_d = check_err_q;
`endif
        unique case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    sel_in_d    = idx_q;
                    input_val_d = in_data;
                    busy_d      = 1'b1;
                    in_ready_d  = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_HOLD;
`ifdef MATMUL_DRV_CHECK_EN
                    ops_d[idx_q] = in_data;
`endif
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        execute_d = 1'b1;
                        state_d   = S_EXEC;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        in_ready_d = 1'b1;
                        state_d    = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EXEC: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d     = '0;
                    k_d       = '0;
                    sel_out_d = '0;
                    state_d   = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d       = '0;
                    out_data_d  = mm_result;
                    out_idx_d   = k_q;
                    out_last_d  = (k_q == 2'd3);
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
`ifdef MATMUL_DRV_CHECK_EN
                    if (mm_result != gold_k) check_err_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    if (k_q == 2'd3) begin
                        busy_d     = 1'b0;
                        idx_d      = '0;
                        in_ready_d = 1'b1;
                        state_d    = S_LOAD;
                    end else begin
                        k_d       = k_q + 2'd1;
                        sel_out_d = k_q + 2'd1;
                        state_d   = S_SETTLE;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            sel_in_q    <= '0;
            input_val_q <= '0;
            execute_q   <= 1'b0;
            sel_out_q   <= '0;
`ifdef MATMUL_DRV_CHECK_EN
            for (int i = 0; i < 8; i++) ops_q[i] <= '0;
            check_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            sel_in_q    <= sel_in_d;
            input_val_q <= input_val_d;
            execute_q   <= execute_d;
            sel_out_q   <= sel_out_d;
`ifdef MATMUL_DRV_CHECK_EN
            ops_q       <= ops_d;
            check_err_q <= check_err_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_idx      = out_idx_q;
    assign out_last     = out_last_q;
    assign busy         = busy_q;
    assign mm_sel_in    = sel_in_q;
    assign mm_input_val = input_val_q;
    assign mm_execute   = execute_q;
    assign mm_sel_out   = sel_out_q;

endmodule

// File: tb/tb_matmul_gpio_driver.sv
// Testbench for matmul_gpio_driver with a behavioural matrix_multiply peer.
// Set MATMUL_DRV_CHECK_EN to also exercise the check_err output.
module tb_matmul_gpio_driver;

    localparam int HC = 2;
    localparam int EW = 4;
    localparam int ST = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic [2:0]  mm_sel_in;
    logic [7:0]  mm_input_val;
    logic        mm_execute;
    logic [1:0]  mm_sel_out;
    logic [16:0] mm_result;
`ifdef MATMUL_DRV_CHECK_EN
    logic        check_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    matmul_gpio_driver #(
        .HOLD_CYCLES(HC), .EXEC_WAIT(EW), .SETTLE(ST)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy),
        .mm_sel_in(mm_sel_in), .mm_input_val(mm_input_val),
        .mm_execute(mm_execute), .mm_sel_out(mm_sel_out),
        .mm_result(mm_result)
`ifdef MATMUL_DRV_CHECK_EN
       ,.check_err(check_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Matrix product from the byte order A00,A01,A10,A11,B00,B01,B10,B11
    function automatic logic [16:0] ref_c(input logic [7:0] b [8], input int k);
        int r, c, s;
        r = k / 2;
        c = k % 2;
        s = 0;
        for (int j = 0; j < 2; j++)
            s += int'(b[2*r + j]) * int'(b[4 + 2*j + c]);
        return 17'(s);
    endfunction

    // Behavioural matrix_multiply peer
    logic [7:0]  mm_mem [8];
    logic [16:0] mm_c [4];
    bit          force_c01 = 1'b0;

    always @(posedge clk) begin
        mm_mem[mm_sel_in] <= mm_input_val;
        if (mm_execute)
            for (int k = 0; k < 4; k++) mm_c[k] <= ref_c(mm_mem, k);
    end

    assign mm_result = (force_c01 && mm_sel_out == 2'd1) ? 17'd0
                                                         : mm_c[mm_sel_out];

    // Protocol monitors: operand hold time, execute width, first-result latency
    int   cyc = 0;
    logic [10:0] prev_pair = '0;
    int   stable_cnt = 0;
    logic prev_in_ready = 1'b0;
    logic prev_rst = 1'b1;
    int   exec_run = 0;
    int   exec_cyc = 0;
    int   n_exec = 0;
    bit   first_pend = 1'b0;
    logic prev_ov = 1'b0;

    always @(negedge clk) begin
        logic [10:0] pair;
        cyc++;
        pair = {mm_sel_in, mm_input_val};
        if (pair != prev_pair) begin
            if (!reset && !prev_rst) begin
                check("hold_len", 64'(stable_cnt >= HC), 1);
                check("chg_when_ready", prev_in_ready, 1);
            end
            stable_cnt = 1;
        end else begin
            stable_cnt++;
        end
        prev_pair = pair;
        prev_in_ready = in_ready;
        prev_rst = reset;
        if (mm_execute === 1'b1) begin
            if (exec_run == 0) begin
                exec_cyc = cyc;
                first_pend = 1'b1;
            end
            exec_run++;
        end else if (exec_run != 0) begin
            check("exec_width", exec_run, 1);
            exec_run = 0;
            n_exec++;
        end
        if (out_valid && !prev_ov && first_pend) begin
            check("first_latency", cyc - exec_cyc, EW + ST + 1);
            first_pend = 1'b0;
        end
        prev_ov = out_valid;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_set(input logic [7:0] b [8], input bit gaps,
                            input int nbytes);
        int n;
        for (int i = 0; i < nbytes; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = b[i];
            n = 0;
            while (!in_ready && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) check("in_timeout", 0, 1);
            tick();
            check("sel_in", mm_sel_in, i);
            check("input_val", mm_input_val, b[i]);
            check("busy_load", busy, 1);
            check("in_ready_low", in_ready, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic get_results(input logic [16:0] exp [4], input int stall_k,
                               input bit rnd, input int err_at);
        int n;
        for (int k = 0; k < 4; k++) begin
            if (k == stall_k) begin
                out_ready = 1'b0;
                n = 0;
                while (!out_valid && n < 300) begin
                    tick();
                    n++;
                end
                if (n >= 300) check("stall_timeout", 0, 1);
                repeat (10) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, exp[k]);
                    check("stall_sel_out", mm_sel_out, k);
                    tick();
                end
            end
            n = 0;
            while (n < 300) begin
                out_ready = rnd ? 1'($urandom % 2) : 1'b1;
                if (out_valid && out_ready) break;
                tick();
                n++;
            end
            if (n >= 300) check("out_timeout", 0, 1);
            check("out_data", out_data, exp[k]);
            check("out_idx", out_idx, k);
            check("out_last", out_last, 64'(k == 3));
            check("sel_out", mm_sel_out, k);
`ifdef MATMUL_DRV_CHECK_EN
            check("check_err", check_err, 64'(err_at >= 0 && k >= err_at));
`else
            if (err_at > 4) check("err_at", 0, 1);
`endif
            tick();
            out_ready = 1'b0;
            check("valid_drop", out_valid, 0);
        end
        check("busy_done", busy, 0);
        check("ready_done", in_ready, 1);
    endtask

    logic [7:0]  b [8];
    logic [16:0] e [4];
    int          ex0;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_sel_in", mm_sel_in, 0);
        check("rst_input_val", mm_input_val, 0);
        check("rst_execute", mm_execute, 0);
        check("rst_sel_out", mm_sel_out, 0);
`ifdef MATMUL_DRV_CHECK_EN
        check("rst_check_err", check_err, 0);
`endif
        reset = 1'b0;
        tick();
        check("ready_after_rst", in_ready, 1);

        // Basic product, continuous in_valid
        b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        e = '{17'd19, 17'd22, 17'd43, 17'd50};
        ex0 = n_exec;
        load_set(b, 1'b0, 8);
        get_results(e, -1, 1'b0, -1);
        check("exec_count", n_exec - ex0, 1);

        // Maximum operands
        b = '{default: 8'd255};
        e = '{default: 17'd130050};
        load_set(b, 1'b0, 8);
        get_results(e, -1, 1'b0, -1);

        // Backpressure on C01
        b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        e = '{17'd19, 17'd22, 17'd43, 17'd50};
        load_set(b, 1'b0, 8);
        get_results(e, 1, 1'b0, -1);

        // Reset part-way through a load discards the partial set
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        load_set(b, 1'b1, 5);
        reset = 1'b1;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_sel_in", mm_sel_in, 0);
        reset = 1'b0;
        tick();
        b = '{8'd2, 8'd0, 8'd0, 8'd2, 8'd3, 8'd1, 8'd4, 8'd1};
        e = '{17'd6, 17'd2, 17'd8, 17'd2};
        load_set(b, 1'b0, 8);
        get_results(e, -1, 1'b0, -1);

        // Random operands, random input gaps and random output backpressure
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 8; i++) b[i] = 8'($urandom_range(0, 255));
            for (int k = 0; k < 4; k++) e[k] = ref_c(b, k);
            load_set(b, 1'b1, 8);
            get_results(e, -1, 1'b1, -1);
        end

`ifdef MATMUL_DRV_CHECK_EN
        // Corrupted C01 from the peer must raise a sticky check_err
        force_c01 = 1'b1;
        b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        e = '{17'd19, 17'd0, 17'd43, 17'd50};
        load_set(b, 1'b0, 8);
        get_results(e, -1, 1'b0, 1);
        repeat (3) tick();
        check("err_sticky", check_err, 1);
        force_c01 = 1'b0;
        reset = 1'b1;
        tick();
        check("err_cleared", check_err, 0);
        reset = 1'b0;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
